// File: rtl/mem_byte_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_loader_if
// Description : Bundles the control, byte-stream and memory-write signals
//               of mem_byte_loader. The master side (host/boot ROM) drives
//               the command and byte stream. The slave side (the loader)
//               drives the memory write port and status.
//               Optional macro LOADER_CHECKSUM_EN adds the checksum signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_byte_loader_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [31:0]      base_addr;
    logic [31:0]      word_count;
    logic             abort;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic             busy;
    logic             done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    modport master (
`ifdef LOADER_CHECKSUM_EN
        input  checksum,
`endif
        output start, base_addr, word_count, abort, in_valid, in_data,
        input  in_ready, mem_addr, mem_wdata, mem_we, busy, done
    );

    modport slave (
`ifdef LOADER_CHECKSUM_EN
        output checksum,
`endif
        input  start, base_addr, word_count, abort, in_valid, in_data,
        output in_ready, mem_addr, mem_wdata, mem_we, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mem_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_loader
// Description : Packs a valid/ready byte stream big-endian into WIDTH-bit
//               words and writes them to consecutive word addresses of the
//               memory write port. This preloads memory before the core runs.
//               Defining LOADER_CHECKSUM_EN adds a 32-bit running sum of
//               the written words.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_loader #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_byte_loader_if.slave bus
);

    localparam int c_BYTES = WIDTH / 8;
    localparam int c_IDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_mem_addr;
    logic [31:0]        w_addr_next;
    logic [31:0]        r_remaining;
    logic [31:0]        w_rem_next;
    logic [WIDTH-1:0]   r_mem_wdata;
    logic [WIDTH-1:0]   w_wdata_next;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_next;
    logic               r_in_ready;
    logic               r_mem_we;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_start_ok;

    // in_ready is only ever high in RECV, so this is the byte handshake
    assign w_accept   = r_in_ready & bus.in_valid;
    // abort beats start when both arrive in IDLE
    assign w_start_ok = (r_state == S_IDLE) & bus.start & ~bus.abort;

    // Next-state and next-datapath values; abort has priority everywhere
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_mem_addr;
        w_rem_next   = r_remaining;
        w_wdata_next = r_mem_wdata;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_addr_next  = bus.base_addr;
                    w_rem_next   = bus.word_count;
                    w_idx_next   = '0;
                    w_state_next = (bus.word_count != 32'd0) ? S_RECV : S_DONE;
                end
            end
            S_RECV: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    // byte 0 lands in the top lane, later bytes move down
                    for (int b = 0; b < c_BYTES; b++) begin
                        if (r_idx == c_IDX_W'(b)) begin
                            w_wdata_next[WIDTH-1-8*b -: 8] = bus.in_data;
                        end
                    end
                    if (r_idx == c_LAST_IDX) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_idx_next = r_idx + c_IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (bus.abort) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_addr_next  = r_mem_addr + 32'd1;
                    w_rem_next   = r_remaining - 32'd1;
                    w_idx_next   = '0;
                    w_state_next = (r_remaining == 32'd1) ? S_DONE : S_RECV;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == S_RECV);
            r_mem_we   <= (w_state_next == S_WRITE);
            r_busy     <= (w_state_next == S_RECV) || (w_state_next == S_WRITE);
            r_done     <= (w_state_next == S_DONE);
        end
    end

    // Address, word assembly, byte index and remaining-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
        end else begin
            r_mem_addr  <= w_addr_next;
            r_mem_wdata <= w_wdata_next;
            r_idx       <= w_idx_next;
            r_remaining <= w_rem_next;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of every word actually written, restarted by each load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_mem_we) begin
            r_checksum <= r_checksum + 32'(r_mem_wdata);
        end
    end

    assign bus.checksum = r_checksum;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_loader
// Description : Directed self-checking bench for mem_byte_loader (WIDTH=32).
//               The checksum checks are included when LOADER_CHECKSUM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt  = 0;
    bit          busy_seen = 1'b0;

    mem_byte_loader_if #(.WIDTH(32)) bus();

    mem_byte_loader #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record memory writes and status mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] getq(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] cnt);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = cnt;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick();
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        chk("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.abort      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
        chk("rst_busy",      {31'd0, bus.busy},     32'd0);
        chk("rst_done",      {31'd0, bus.done},     32'd0);
        chk("rst_mem_addr",  bus.mem_addr,          32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,         32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("rst_checksum",  bus.checksum,          32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Two words back-to-back
        clear_mon();
        do_start(32'h10, 32'd2);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        repeat (6) tick();
        chk("t1_nwrites", wr_addr_q.size(),  32'd2);
        chk("t1_addr0",   getq(wr_addr_q, 0), 32'h10);
        chk("t1_data0",   getq(wr_data_q, 0), 32'h11223344);
        chk("t1_addr1",   getq(wr_addr_q, 1), 32'h11);
        chk("t1_data1",   getq(wr_data_q, 1), 32'h55667788);
        chk("t1_spacing", (wr_cyc_q.size() == 2) ? (wr_cyc_q[1] - wr_cyc_q[0]) : -1, 32'd5);
        chk("t1_done",    done_cnt,          32'd1);
`ifdef LOADER_CHECKSUM_EN
        chk("t1_checksum", bus.checksum,     32'h6688AACC);
`endif

        // Gapped stream, with a start pulse mid-load that must be ignored
        clear_mon();
        do_start(32'h10, 32'd2);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        do_start(32'h99, 32'd5);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        send_word(32'h55667788, 1);
        repeat (6) tick();
        chk("t2_nwrites", wr_addr_q.size(),  32'd2);
        chk("t2_addr0",   getq(wr_addr_q, 0), 32'h10);
        chk("t2_data0",   getq(wr_data_q, 0), 32'h11223344);
        chk("t2_addr1",   getq(wr_addr_q, 1), 32'h11);
        chk("t2_data1",   getq(wr_data_q, 1), 32'h55667788);
        chk("t2_done",    done_cnt,          32'd1);

        // Zero-word load: done one cycle after start, never busy
        clear_mon();
        do_start(32'h0, 32'd0);
        @(negedge clk);
        chk("t3_done_pulse", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        chk("t3_done_clear", {31'd0, bus.done}, 32'd0);
        tick();
        chk("t3_nwrites",  wr_addr_q.size(),    32'd0);
        chk("t3_busy",     {31'd0, busy_seen},  32'd0);

        // start and abort together in IDLE: abort wins
        clear_mon();
        bus.abort = 1'b1;
        do_start(32'h50, 32'd1);
        bus.abort = 1'b0;
        repeat (3) tick();
        chk("sa_busy", {31'd0, busy_seen}, 32'd0);
        chk("sa_done", done_cnt,           32'd0);

        // Abort after two bytes, then a clean reload
        clear_mon();
        do_start(32'h30, 32'd3);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        repeat (8) tick();
        chk("t4_nwrites",  wr_addr_q.size(),      32'd0);
        chk("t4_done",     done_cnt,              32'd0);
        chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
        clear_mon();
        do_start(32'h20, 32'd1);
        send_word(32'hA1B2C3D4, 0);
        repeat (5) tick();
        chk("t4_re_nwrites", wr_addr_q.size(),   32'd1);
        chk("t4_re_addr",    getq(wr_addr_q, 0), 32'h20);
        chk("t4_re_data",    getq(wr_data_q, 0), 32'hA1B2C3D4);
        chk("t4_re_done",    done_cnt,           32'd1);
`ifdef LOADER_CHECKSUM_EN
        chk("t4_checksum",   bus.checksum,       32'hA1B2C3D4);
`endif

        // Address wraps past 0xFFFFFFFF
        clear_mon();
        do_start(32'hFFFFFFFF, 32'd2);
        send_word(32'h01020304, 0);
        send_word(32'hCAFEBABE, 0);
        repeat (6) tick();
        chk("t5_nwrites", wr_addr_q.size(),   32'd2);
        chk("t5_addr0",   getq(wr_addr_q, 0), 32'hFFFFFFFF);
        chk("t5_addr1",   getq(wr_addr_q, 1), 32'h00000000);
        chk("t5_data1",   getq(wr_data_q, 1), 32'hCAFEBABE);

        // Words summing to zero mod 2^32
        clear_mon();
        do_start(32'h100, 32'd2);
        send_word(32'h00000001, 0);
        send_word(32'hFFFFFFFF, 0);
        repeat (6) tick();
        chk("t6_data0", getq(wr_data_q, 0), 32'h00000001);
        chk("t6_data1", getq(wr_data_q, 1), 32'hFFFFFFFF);
        chk("t6_done",  done_cnt,           32'd1);
`ifdef LOADER_CHECKSUM_EN
        chk("t6_checksum", bus.checksum,    32'h00000000);
`endif

        // Reset during the write cycle drops mem_we immediately
        clear_mon();
        do_start(32'h40, 32'd1);
        send_word(32'h12345678, 0);
        chk("rm_we_before", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_we_async",  {31'd0, bus.mem_we}, 32'd0);
        chk("rm_addr",      bus.mem_addr,        32'd0);
        chk("rm_busy",      {31'd0, bus.busy},   32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
